// File: rtl/sel_shift_seq_if.sv
// Bus between the sequencing shift-register pair and its select mux / control.
// The optional shift freeze is present only when SEQ_HOLD_EN is defined.
// Handshake: start is sampled only while busy is low; done is a one-cycle
// pulse after the last shift, and busy stays high from accept through done.
interface sel_shift_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       mode;
    logic             selout;
`ifdef SEQ_HOLD_EN
    logic             hold;
`endif
    logic [2:0]       muxsel;
    logic [WIDTH-1:0] regl;
    logic [WIDTH-1:0] regh;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

`ifdef SEQ_HOLD_EN
    modport master (
        output start, mode, selout, hold,
        input  muxsel, regl, regh, busy, done, dbg_state
    );
    modport slave (
        input  start, mode, selout, hold,
        output muxsel, regl, regh, busy, done, dbg_state
    );
`else
    modport master (
        output start, mode, selout,
        input  muxsel, regl, regh, busy, done, dbg_state
    );
    modport slave (
        input  start, mode, selout,
        output muxsel, regl, regh, busy, done, dbg_state
    );
`endif
endinterface

// File: rtl/sel_shift_seq.sv
// Sequencing shift-register pair: latches a select code on start, presents it
// to the serial-bit mux and shifts the returned bit into regl, then regh.
// Optional feature macro: SEQ_HOLD_EN (adds a hold input that freezes shifting).
// WIDTH legal range is 3..16 because the mux taps bit 2 of each register.
module sel_shift_seq #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    sel_shift_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT_L = 2'd1,
        SHIFT_H = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] regl_q, regl_d;
    logic [WIDTH-1:0] regh_q, regh_d;
    logic             shift_en;

`ifdef SEQ_HOLD_EN
    assign shift_en = ~bus.hold;
`else
    assign shift_en = 1'b1;
`endif

    // State and datapath registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= '0;
            cnt_q   <= '0;
            regl_q  <= '0;
            regh_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            regl_q  <= regl_d;
            regh_q  <= regh_d;
        end
    end

    // Next-state and shift logic; only the register of the active phase moves.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        regl_d  = regl_q;
        regh_d  = regh_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SHIFT_L;
                    mode_d  = bus.mode;
                    cnt_d   = '0;
                end
            end
            SHIFT_L: begin
                if (shift_en) begin
                    regl_d = {bus.selout, regl_q[WIDTH-1:1]};
                    if (cnt_q == CNT_LAST) begin
                        state_d = SHIFT_H;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SHIFT_H: begin
                if (shift_en) begin
                    regh_d = {bus.selout, regh_q[WIDTH-1:1]};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.muxsel    = 3'b000;
        bus.busy      = (state_q != IDLE);
        bus.done      = (state_q == DONE);
        bus.regl      = regl_q;
        bus.regh      = regh_q;
        bus.dbg_state = state_q;
        if (state_q == SHIFT_L || state_q == SHIFT_H) begin
            bus.muxsel = mode_q;
        end
    end
endmodule

// File: tb/tb_sel_shift_seq.sv
// Bench for sel_shift_seq: directed cases plus random sequences, with an
// external select-mux model and a scoreboard checked on every done pulse.
module tb_sel_shift_seq;
    localparam int W  = 8;
    localparam int EW = 3 + 8 + 2 * W;

    logic clk;
    logic reset;
    logic thrsh;

    sel_shift_seq_if #(.WIDTH(W)) bus ();

    sel_shift_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];

    logic [W-1:0] m_regl;
    logic [W-1:0] m_regh;

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Select mux: which bit each code picks.
    function automatic logic mux_bit(input logic [2:0] sel, input logic [W-1:0] l,
                                     input logic [W-1:0] h, input logic t);
        case (sel)
            3'b000:  mux_bit = 1'b0;
            3'b001:  mux_bit = 1'b1;
            3'b010:  mux_bit = t;
            3'b011:  mux_bit = h[0];
            3'b100:  mux_bit = l[0];
            3'b101:  mux_bit = h[2];
            default: mux_bit = l[2];
        endcase
    endfunction

    always_comb bus.selout = mux_bit(bus.muxsel, bus.regl, bus.regh, thrsh);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: for each phase, W times take the selected bit and drop it in at the top.
    task automatic model_seq(input logic [2:0] m, input logic [2*W-1:0] pat, input int holds);
        logic b;
        for (int i = 0; i < W; i++) begin
            b = mux_bit(m, m_regl, m_regh, pat[i]);
            m_regl = (m_regl >> 1) | (W'(b) << (W - 1));
        end
        for (int i = 0; i < W; i++) begin
            b = mux_bit(m, m_regl, m_regh, pat[W + i]);
            m_regh = (m_regh >> 1) | (W'(b) << (W - 1));
        end
        exp_q.push_back({m, 8'(2 * W + 1 + holds), m_regl, m_regh});
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (bus.busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (bus.busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: busy still high after %0d cycles", name, k);
        end
        @(negedge clk);
    endtask

    // One full sequence; glitch pulses an extra start in SHIFT_H that must be ignored.
    task automatic run_seq(input logic [2:0] m, input logic [2*W-1:0] pat, input bit glitch);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = m;
        model_seq(m, pat, 0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.mode  = $urandom_range(0, 7);
        thrsh     = pat[0];
        for (int i = 1; i < 2 * W; i++) begin
            @(negedge clk);
            thrsh     = pat[i];
            bus.start = glitch && (i == W + 2);
            if (glitch && i == W + 2) bus.mode = 3'b001;
        end
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle("seq_end");
        repeat (2) @(negedge clk);
    endtask

    // Monitor: busy-length, muxsel and result checks against the expected queue.
    int busy_cnt = 0;
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (bus.busy) busy_cnt++;
        else busy_cnt = 0;
        if (bus.busy && !bus.done && exp_q.size() > 0)
            check("muxsel_busy", 32'(bus.muxsel), 32'(exp_q[0][2*W+10:2*W+8]));
        if (bus.done) begin
            check("muxsel_done", 32'(bus.muxsel), 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done with no sequence expected at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("regl", 32'(bus.regl), 32'(e[2*W-1:W]));
                check("regh", 32'(bus.regh), 32'(e[W-1:0]));
                check("busy_len", 32'(busy_cnt), 32'(e[2*W+7:2*W]));
            end
        end
    end

    // Safety net against a hung run.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2*W-1:0] pat;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 3'b000;
        thrsh     = 1'b0;
`ifdef SEQ_HOLD_EN
        bus.hold  = 1'b0;
`endif
        m_regl = '0;
        m_regh = '0;
        repeat (3) @(negedge clk);
        check("rst_regl", 32'(bus.regl), 32'd0);
        check("rst_regh", 32'(bus.regh), 32'd0);
        check("rst_muxsel", 32'(bus.muxsel), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Constant one, constant zero, threshold, rotate.
        run_seq(3'b001, '0, 1'b0);
        run_seq(3'b000, '0, 1'b0);
        pat = '0;
        pat[0] = 1'b1;
        run_seq(3'b010, pat, 1'b0);
        run_seq(3'b100, '0, 1'b0);

        // Ignored start during SHIFT_H.
        run_seq(3'b000, '0, 1'b1);

        // Reset after 5 shifts in SHIFT_L.
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 3'b001;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        m_regl = '0;
        m_regh = '0;
        @(negedge clk);
        check("abort_state", 32'(bus.dbg_state), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_regl", 32'(bus.regl), 32'd0);
        check("abort_regh", 32'(bus.regh), 32'd0);
        check("abort_muxsel", 32'(bus.muxsel), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        run_seq(3'b001, '0, 1'b0);

`ifdef SEQ_HOLD_EN
        // Hold for 3 cycles in the middle of SHIFT_L.
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 3'b001;
        model_seq(3'b001, '0, 3);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.hold = 1'b1;
        repeat (3) @(negedge clk);
        bus.hold = 1'b0;
        wait_idle("hold_end");
        repeat (2) @(negedge clk);
`endif

        // Random sequences.
        for (int r = 0; r < 14; r++) begin
            pat = {$urandom, $urandom};
            run_seq(3'($urandom_range(0, 7)), pat, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
